// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared types and constants for the LED display arbiter
package led_arb_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    IDLE      = 2'd1,
    OWN       = 2'd2
  } arb_state_t;

  localparam logic [3:0] LED_OFF = 4'b0000;

  // Wide enough to hold HOLD_CYCLES itself so the saturating counter never wraps.
  function automatic int cnt_width(input int hold_cycles);
    return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/led_rr_pick.sv
// rtl/led_rr_pick.sv - combinational round-robin picker
// Returns the first eligible request at or above i_ptr, wrapping, skipping i_excl.
module led_rr_pick
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  input  logic [NUM_REQ-1:0] i_excl,
  output logic [NUM_REQ-1:0] o_pick,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_cand;
  int                 w_idx;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!o_valid && w_cand[w_idx[PW-1:0]]) begin
        o_pick[w_idx[PW-1:0]] = 1'b1;
        o_valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_display_arbiter.sv
// rtl/led_display_arbiter.sv - round-robin owner of the four fabric LEDs
// Grants one requester at a time with a minimum hold so each pattern stays visible.
module led_display_arbiter
  import led_arb_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         HOLD_CYCLES  = 5_000_000,
  parameter logic [3:0] IDLE_PATTERN = 4'b0001
) (
  input  logic                 FAB_CLK,
  input  logic                 FAB_RESET,
  input  logic                 FAB_LOCK,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [4*NUM_REQ-1:0] REQ_PATTERN,
  output logic [NUM_REQ-1:0]   GNT,
  output logic                 OWNER_VALID,
  output logic                 LED1,
  output logic                 LED2,
  output logic                 LED3,
  output logic                 LED4
);

  localparam int            PW       = $clog2(NUM_REQ);
  localparam int            CW       = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic               r_owner_valid;
  logic [3:0]         r_led, w_led_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [PW-1:0]      r_ptr, w_ptr_nxt;

  logic [3:0]         w_pat [NUM_REQ];
  logic [PW-1:0]      w_owner;
  logic [PW-1:0]      w_owner_inc;
  logic [PW-1:0]      w_pick_idx;
  logic [PW-1:0]      w_pick_ptr;
  logic [NUM_REQ-1:0] w_pick_excl;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_pick_valid;
  logic               w_hold_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pat
    assign w_pat[g] = REQ_PATTERN[4*g +: 4];
  end

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) w_owner = PW'(i);
    end
  end

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PW'(i);
    end
  end

  assign w_owner_inc = (w_owner == PW'(NUM_REQ - 1)) ? '0 : w_owner + 1'b1;
  assign w_hold_done = (r_cnt == HOLD_VAL);

  // While owning, search from the slot after the owner and never re-pick the owner.
  assign w_pick_ptr  = (r_state == OWN) ? w_owner_inc : r_ptr;
  assign w_pick_excl = (r_state == OWN) ? r_gnt : '0;

  led_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .i_req   (REQ),
    .i_ptr   (w_pick_ptr),
    .i_excl  (w_pick_excl),
    .o_pick  (w_pick),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_led_nxt   = r_led;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    if (!FAB_LOCK) begin
      w_state_nxt = WAIT_LOCK;
      w_gnt_nxt   = '0;
      w_led_nxt   = LED_OFF;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_led_nxt   = IDLE_PATTERN;
          w_cnt_nxt   = '0;
        end
        IDLE: begin
          w_led_nxt = IDLE_PATTERN;
          if (w_pick_valid) begin
            w_state_nxt = OWN;
            w_gnt_nxt   = w_pick;
            w_led_nxt   = w_pat[w_pick_idx];
            w_cnt_nxt   = '0;
          end
        end
        OWN: begin
          if (w_hold_done && (!REQ[w_owner] || w_pick_valid)) begin
            w_ptr_nxt = w_owner_inc;
            w_cnt_nxt = '0;
            if (w_pick_valid) begin
              w_gnt_nxt = w_pick;
              w_led_nxt = w_pat[w_pick_idx];
            end else begin
              w_state_nxt = IDLE;
              w_gnt_nxt   = '0;
              w_led_nxt   = IDLE_PATTERN;
            end
          end else begin
            if (!w_hold_done) w_cnt_nxt = r_cnt + 1'b1;
            // A dropped request leaves the last pattern frozen until release.
            if (REQ[w_owner]) w_led_nxt = w_pat[w_owner];
          end
        end
        default: begin
          w_state_nxt = WAIT_LOCK;
          w_gnt_nxt   = '0;
          w_led_nxt   = LED_OFF;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      r_state       <= WAIT_LOCK;
      r_gnt         <= '0;
      r_owner_valid <= 1'b0;
      r_led         <= LED_OFF;
      r_cnt         <= '0;
      r_ptr         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_owner_valid <= |w_gnt_nxt;
      r_led         <= w_led_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ptr         <= w_ptr_nxt;
    end
  end

  assign GNT         = r_gnt;
  assign OWNER_VALID = r_owner_valid;
  assign LED1        = r_led[0];
  assign LED2        = r_led[1];
  assign LED3        = r_led[2];
  assign LED4        = r_led[3];

endmodule

// File: tb/tb_led_display_arbiter.sv
// tb/tb_led_display_arbiter.sv - scoreboard bench for led_display_arbiter
module tb_led_display_arbiter;

  localparam logic [15:0] P = 16'hCA53;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic [3:0]  req;
  logic [15:0] pat;
  logic [3:0]  gnt;
  logic        ov;
  logic        led1, led2, led3, led4;

  logic [8:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stepn  = 0;

  always #5 clk = ~clk;

  led_display_arbiter #(
    .NUM_REQ      (4),
    .HOLD_CYCLES  (4),
    .IDLE_PATTERN (4'b0001)
  ) dut (
    .FAB_CLK     (clk),
    .FAB_RESET   (rst),
    .FAB_LOCK    (lock),
    .REQ         (req),
    .REQ_PATTERN (pat),
    .GNT         (gnt),
    .OWNER_VALID (ov),
    .LED1        (led1),
    .LED2        (led2),
    .LED3        (led3),
    .LED4        (led4)
  );

  always begin
    logic [8:0] e;
    logic [8:0] a;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt, ov, led4, led3, led2, led1};
      stepn++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d gnt/ov/led: got %b/%b/%h expected %b/%b/%h",
                 stepn, a[8:5], a[4], a[3:0], e[8:5], e[4], e[3:0]);
      end
    end
  end

  task automatic step(input logic l, input logic r, input logic [3:0] rq,
                      input logic [15:0] pt, input logic [3:0] eg, input logic [3:0] el);
    @(negedge clk);
    lock = l;
    rst  = r;
    req  = rq;
    pat  = pt;
    exp_q.push_back({eg, (eg != 4'b0000), el});
  endtask

  initial begin
    logic [3:0] rot_led [4];
    rot_led[0] = 4'h5; rot_led[1] = 4'hA; rot_led[2] = 4'hC; rot_led[3] = 4'h3;
    rst = 1'b1; lock = 1'b0; req = 4'b0; pat = P;

    // reset and locked-out period, then lock and first grant
    step(0, 1, 4'b1111, P, 4'b0000, 4'h0);
    repeat (4) step(0, 0, 4'b1111, P, 4'b0000, 4'h0);
    step(1, 0, 4'b1111, P, 4'b0000, 4'h1);
    step(1, 0, 4'b1111, P, 4'b0001, 4'h3);

    // all requesting: rotation with five cycles per owner
    repeat (4) step(1, 0, 4'b1111, P, 4'b0001, 4'h3);
    for (int o = 0; o < 4; o++) begin
      repeat (5) step(1, 0, 4'b1111, P, 4'(1 << ((o + 1) % 4)), rot_led[o]);
    end
    step(1, 0, 4'b0000, P, 4'b0000, 4'h1);

    // sole requester 2 keeps ownership, pattern change seen one cycle later
    repeat (20) step(1, 0, 4'b0100, P, 4'b0100, 4'hA);
    step(1, 0, 4'b0100, 16'hC753, 4'b0100, 4'h7);
    step(1, 0, 4'b0000, P, 4'b0000, 4'h1);

    // one-cycle pulse from requester 1: frozen pattern for the full hold
    step(1, 0, 4'b0010, P, 4'b0010, 4'h5);
    repeat (4) step(1, 0, 4'b0000, 16'hCAF3, 4'b0010, 4'h5);
    step(1, 0, 4'b0000, P, 4'b0000, 4'h1);

    // lock lost while requester 3 owns; pointer stays at 0
    step(1, 1, 4'b0000, P, 4'b0000, 4'h0);
    step(1, 0, 4'b0000, P, 4'b0000, 4'h1);
    step(1, 0, 4'b1000, P, 4'b1000, 4'hC);
    step(1, 0, 4'b1000, P, 4'b1000, 4'hC);
    step(0, 0, 4'b1000, P, 4'b0000, 4'h0);
    step(1, 0, 4'b1001, P, 4'b0000, 4'h1);
    step(1, 0, 4'b1001, P, 4'b0001, 4'h3);

    // handover 0 -> 1, then reset lands on the 1 -> 0 handover edge
    repeat (4) step(1, 0, 4'b1001, P, 4'b0001, 4'h3);
    step(1, 0, 4'b0011, P, 4'b0010, 4'h5);
    repeat (4) step(1, 0, 4'b0011, P, 4'b0010, 4'h5);
    step(1, 1, 4'b0011, P, 4'b0000, 4'h0);
    step(1, 0, 4'b1001, P, 4'b0000, 4'h1);
    step(1, 0, 4'b1001, P, 4'b0001, 4'h3);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/led_display_arbiter.md
# led_display_arbiter

Shares the board's four fabric LEDs (LED1..LED4) between several fabric requesters, such as a heartbeat blinker, a fault indicator, UART activity and reprogramming progress. It runs on the fabric CCC clock and stays dark until the MSS reports ready. Ownership is granted round-robin, with a guaranteed minimum hold time so that patterns remain visible. It sits between the requester blocks and the top-level LED outputs.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 5_000_000, minimum ownership time in FAB_CLK cycles (>= 1)
- IDLE_PATTERN, 4'b0001, LED value shown when nobody owns the LEDs

Ports:
- FAB_CLK, input, 1, fabric clock; all logic is on its rising edge
- FAB_RESET, input, 1, reset; **synchronous, active-high**
- FAB_LOCK, input, 1, MSS ready / clock lock; low forces WAIT_LOCK
- REQ, input, NUM_REQ, level request, one bit per requester
- REQ_PATTERN, input, 4*NUM_REQ, requester i drives bits [4i+3:4i]; bit 0 maps to LED1
- GNT, output, NUM_REQ, one-hot current owner (all zero when none)
- OWNER_VALID, output, 1, high when GNT is non-zero
- LED1..LED4, output, 1 each, registered LED drive

## Operation
- States: WAIT_LOCK, IDLE, OWN.
- Reset: state is WAIT_LOCK; GNT=0; OWNER_VALID=0; LEDs=4'b0000; hold counter=0; round-robin pointer=0.
- WAIT_LOCK:
  - LEDs are 0 and GNT is 0.
  - Moves to IDLE on the first cycle FAB_LOCK=1.
- IDLE:
  - LEDs show IDLE_PATTERN.
  - If any REQ bit is set, grant the first set bit searching upward from the pointer, wrapping; go to OWN.
- OWN:
  - The hold counter increments and saturates at HOLD_CYCLES; hold_done = (counter == HOLD_CYCLES).
  - While REQ[owner]=1, the LEDs follow that owner's REQ_PATTERN each cycle.
  - If REQ[owner] falls before hold_done, the last pattern is frozen on the LEDs until hold_done.
- Release from OWN occurs when hold_done and either REQ[owner]=0 or another REQ bit is set (fairness rotation).
  - On release, the pointer becomes owner+1 (mod NUM_REQ).
  - If any other request is pending, it is granted directly; state stays OWN, the counter clears, and no IDLE bubble occurs.
  - Otherwise the state goes to IDLE.
  - A sole requester that remains asserted keeps ownership indefinitely; the counter stays saturated.
- FAB_LOCK=0 in any state:
  - Next state is WAIT_LOCK, GNT clears, LEDs go to 0, and the counter clears.
  - The pointer is kept.
- FAB_RESET takes priority over everything, including mid-ownership: all outputs return to their reset values on the next edge.

## Timing
- Grant latency: REQ asserted in IDLE at edge n gives GNT, OWNER_VALID and the LEDs valid after edge n+1.
- Pattern latency: a change on REQ_PATTERN of the owner appears on the LEDs one cycle later.
- Handover: if the owner reaches hold_done at edge n with another request pending, the new GNT and its pattern take effect at edge n+1. GNT is never zero and never multi-hot during a handover.
- Minimum ownership is HOLD_CYCLES+1 cycles of GNT high, counted from the grant edge to the release edge.
- Counter width is $clog2(HOLD_CYCLES+1); it must not wrap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package led_arb_pkg holds:
  - the state enum (WAIT_LOCK, IDLE, OWN)
  - LED_OFF = 4'b0000
  - a function computing the counter width
- Sub-module led_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer, and an exclude mask (the current owner).
  - Outputs: one-hot pick and a valid flag.
- The top module holds the FSM, the hold counter, the pointer and the LED/GNT registers.

## Test plan
All scenarios use HOLD_CYCLES=4 and NUM_REQ=4.
1. Reset with FAB_LOCK=0 and REQ=4'b1111 -> LEDs=0 and GNT=0 indefinitely. Raise FAB_LOCK -> IDLE, LEDs=4'b0001; one cycle later GNT=4'b0001.
2. Only REQ[2]=1 with pattern 4'hA, held for 20 cycles -> GNT=4'b0100 throughout, LEDs=4'hA; drop REQ[2] -> IDLE pattern appears on the next edge.
3. All four requests held -> GNT rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001, each held exactly 5 cycles, never zero between owners.
4. REQ[1] pulsed for 1 cycle with pattern 4'h5 -> GNT=4'b0010 for 5 cycles, LEDs frozen at 4'h5, then IDLE.
5. FAB_LOCK dropped mid-ownership of requester 3 -> next edge LEDs=0 and GNT=0. Relock with REQ=4'b1001 -> requester 0 is granted, because the pointer is still 0 (requester 3 never completed a release).
6. FAB_RESET asserted during a handover edge -> all outputs return to their reset values on that edge, and the pointer returns to 0.
